// File: rtl/linebuf_pkg.sv
// Shared types and widths for the line-buffer read scheduler.
package linebuf_pkg;

  localparam int unsigned IMAGE_SIZE  = 16;
  localparam int unsigned KERNEL_SIZE = 3;
  localparam int unsigned NUM_BUFS    = 4;
  localparam int unsigned ADDR_SIZE   = $clog2(IMAGE_SIZE);

  localparam int unsigned COL_W = ADDR_SIZE;
  localparam int unsigned ROW_W = $clog2(IMAGE_SIZE);
  localparam int unsigned BUF_W = $clog2(NUM_BUFS);
  localparam int unsigned OCC_W = $clog2(NUM_BUFS) + 1;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ROWS,
    SWEEP,
    RELEASE,
    DONE
  } sched_state_t;

  // Advance a ring pointer with wrap at NUM_BUFS-1.
  function automatic logic [BUF_W-1:0] buf_inc(input logic [BUF_W-1:0] b);
    return (b == BUF_W'(NUM_BUFS - 1)) ? '0 : b + BUF_W'(1);
  endfunction

endpackage

// File: rtl/linebuf_read_sched_if.sv
// Scheduler-side bus: writer handshakes, row-buffer read port, MAC window stream.
interface linebuf_read_sched_if;
  import linebuf_pkg::*;

  logic             frame_start;
  logic             row_wr_done;
  logic             out_ready;
  logic             rd_en;
  logic [COL_W-1:0] rd_addr;
  logic [BUF_W-1:0] rd_base_buf;
  logic             win_valid;
  logic [COL_W-1:0] win_col;
  logic [ROW_W-1:0] win_row;
  logic             buf_free;
  logic [OCC_W-1:0] rows_avail;
  logic             wr_full;
  logic             overflow_err;
  logic             frame_done;

  modport master (
    input  frame_start, row_wr_done, out_ready,
    output rd_en, rd_addr, rd_base_buf, win_valid, win_col, win_row,
           buf_free, rows_avail, wr_full, overflow_err, frame_done
  );

  modport slave (
    output frame_start, row_wr_done, out_ready,
    input  rd_en, rd_addr, rd_base_buf, win_valid, win_col, win_row,
           buf_free, rows_avail, wr_full, overflow_err, frame_done
  );

endinterface

// File: rtl/row_occupancy_cnt.sv
// Count of committed-but-unreleased rows, with full flag and sticky overflow.
module row_occupancy_cnt
  import linebuf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OCC_W-1:0] cnt_o,
  output logic             full_o,
  output logic             ovf_o
);

  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             full_q, full_d;
  logic             ovf_q, ovf_d;

  // Next count: simultaneous inc/dec cancel; a write into a full ring is dropped and flagged.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (inc_i && full_q) begin
      ovf_d = 1'b1;
    end
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && dec_i) begin
      cnt_d = cnt_q;
    end else if (inc_i && !full_q) begin
      cnt_d = cnt_q + OCC_W'(1);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - OCC_W'(1);
    end
    full_d = (cnt_d == OCC_W'(NUM_BUFS));
  end

  // Occupancy state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign full_o = full_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/linebuf_read_sched.sv
// Read-side scheduler: waits for KERNEL_SIZE rows, sweeps columns under
// valid/ready backpressure, then releases the oldest row buffer.
module linebuf_read_sched
  import linebuf_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  linebuf_read_sched_if.master bus
);

  sched_state_t     state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [BUF_W-1:0] base_q, base_d;
  logic             win_valid_q, win_valid_d;
  logic [COL_W-1:0] win_col_q, win_col_d;

  logic             advance_c;
  logic             rd_en_c;
  logic             buf_free_c;
  logic             occ_clr_c;
  logic             occ_inc_c;
  logic [OCC_W-1:0] rows_avail;
  logic             wr_full;
  logic             overflow_err;

  row_occupancy_cnt u_occ (
    .clk   (clk),
    .rst   (rst),
    .clr_i (occ_clr_c),
    .inc_i (occ_inc_c),
    .dec_i (buf_free_c),
    .cnt_o (rows_avail),
    .full_o(wr_full),
    .ovf_o (overflow_err)
  );

  // Next-state, counters and issue strobes.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    base_d      = base_q;
    rd_en_c     = 1'b0;
    buf_free_c  = 1'b0;
    occ_clr_c   = 1'b0;
    advance_c   = !win_valid_q || bus.out_ready;
    // A row committed during DONE belongs to no frame and is dropped.
    occ_inc_c   = bus.row_wr_done && (state_q != DONE);

    unique case (state_q)
      IDLE: begin
        if (bus.frame_start) begin
          col_d     = '0;
          row_d     = '0;
          base_d    = '0;
          occ_clr_c = 1'b1;
          state_d   = WAIT_ROWS;
        end
      end
      WAIT_ROWS: begin
        if (rows_avail >= OCC_W'(KERNEL_SIZE)) begin
          state_d = SWEEP;
        end
      end
      SWEEP: begin
        if (advance_c) begin
          rd_en_c = 1'b1;
          col_d   = col_q + COL_W'(1);
          if (col_q == COL_W'(IMAGE_SIZE - 1)) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        // Hold the oldest buffer until the last column has left the MAC port.
        if (advance_c) begin
          buf_free_c = 1'b1;
          base_d     = buf_inc(base_q);
          col_d      = '0;
          if (row_q == ROW_W'(IMAGE_SIZE - KERNEL_SIZE)) begin
            state_d = DONE;
          end else begin
            row_d   = row_q + ROW_W'(1);
            state_d = WAIT_ROWS;
          end
        end
      end
      DONE: begin
        occ_clr_c = 1'b1;
        base_d    = '0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Output stage: load on issue, drain when the MAC takes the beat.
    if (rd_en_c) begin
      win_valid_d = 1'b1;
      win_col_d   = col_q;
    end else begin
      win_valid_d = bus.out_ready ? 1'b0 : win_valid_q;
      win_col_d   = win_col_q;
    end
  end

  // Scheduler state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      col_q       <= '0;
      row_q       <= '0;
      base_q      <= '0;
      win_valid_q <= 1'b0;
      win_col_q   <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      base_q      <= base_d;
      win_valid_q <= win_valid_d;
      win_col_q   <= win_col_d;
    end
  end

  assign bus.rd_en        = rd_en_c;
  assign bus.rd_addr      = col_q;
  assign bus.rd_base_buf  = base_q;
  assign bus.win_valid    = win_valid_q;
  assign bus.win_col      = win_col_q;
  assign bus.win_row      = row_q;
  assign bus.buf_free     = buf_free_c;
  assign bus.rows_avail   = rows_avail;
  assign bus.wr_full      = wr_full;
  assign bus.overflow_err = overflow_err;
  assign bus.frame_done   = (state_q == DONE);

endmodule

// File: tb/tb_linebuf_read_sched.sv
// Directed bench for linebuf_read_sched: vector table plus multi-cycle sequences.
module tb_linebuf_read_sched;
  import linebuf_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  linebuf_read_sched_if bus ();

  linebuf_read_sched dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fs;
    logic       wd;
    logic       ordy;
    logic       e_rd_en;
    logic [3:0] e_addr;
    logic       e_wv;
    logic [3:0] e_wc;
    logic [2:0] e_ra;
    logic       e_full;
  } vec_t;

  vec_t tbl [15];

  function automatic vec_t mkv(input logic fs, input logic wd, input logic ordy,
                               input logic rd, input int addr, input logic wv,
                               input int wc, input int ra, input logic full);
    vec_t v;
    v.fs = fs; v.wd = wd; v.ordy = ordy;
    v.e_rd_en = rd; v.e_addr = 4'(addr); v.e_wv = wv;
    v.e_wc = 4'(wc); v.e_ra = 3'(ra); v.e_full = full;
    return v;
  endfunction

  // Expected full output word; base, row, buf_free, overflow and frame_done are 0 here.
  function automatic logic [22:0] mk_exp(input vec_t v);
    return {v.e_rd_en, v.e_addr, 2'b00, v.e_wv, v.e_wc, 4'b0000, 1'b0,
            v.e_ra, v.e_full, 1'b0, 1'b0};
  endfunction

  function automatic logic [22:0] outs();
    return {bus.rd_en, bus.rd_addr, bus.rd_base_buf, bus.win_valid, bus.win_col,
            bus.win_row, bus.buf_free, bus.rows_avail, bus.wr_full,
            bus.overflow_err, bus.frame_done};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fs, input logic wd, input logic ordy);
    bus.frame_start = fs;
    bus.row_wr_done = wd;
    bus.out_ready   = ordy;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_full_frame();
    int   cyc = 0, written = 0, exp_col = 0, exp_row = 0;
    int   beats = 0, rds = 0, bfs = 0, fds = 0, bp_left = 0, post = 0;
    bit   bp_done = 0, fs_done = 0, done = 0;
    logic wd, ordy, fs;
    apply_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1);
    while (cyc < 3000 && post < 3) begin
      @(negedge clk);
      cyc++;
      wd = (cyc % 20 == 0) && (written < 16) && !bus.wr_full;
      if (wd) written++;
      if (!bp_done && bus.win_valid && bus.win_col == 4'd7 && bus.win_row == 4'd1) begin
        bp_left = 5;
        bp_done = 1;
      end
      ordy = (bp_left == 0);
      fs = !fs_done && bus.win_valid && bus.win_row == 4'd2 && bus.win_col == 4'd4;
      if (fs) fs_done = 1;
      drive(fs, wd, ordy);
      #1;
      if (bp_left > 0) begin
        check("bp_hold", 32'({bus.win_valid, bus.win_col, bus.rd_en}), 32'({1'b1, 4'd7, 1'b0}));
        bp_left--;
      end
      if (bus.win_valid && ordy) begin
        check("beat", 32'({bus.win_row, bus.win_col}), 32'({4'(exp_row), 4'(exp_col)}));
        beats++;
        exp_col++;
        if (exp_col == 16) begin
          exp_col = 0;
          exp_row++;
        end
      end
      if (bus.rd_en) rds++;
      if (bus.buf_free) bfs++;
      if (done) post++;
      if (bus.frame_done) begin
        fds++;
        done = 1;
      end
    end
    check("frame_completed", 32'(done), 32'd1);
    check("frame_beats", 32'(beats), 32'd224);
    check("frame_rd_en", 32'(rds), 32'd224);
    check("frame_buf_free", 32'(bfs), 32'd14);
    check("frame_done_cnt", 32'(fds), 32'd1);
    check("frame_bp_seen", 32'(bp_done), 32'd1);
    check("after_done", 32'({bus.rows_avail, bus.rd_base_buf, bus.rd_en}), 32'd0);
  endtask

  task automatic run_overflow();
    int exp_ra;
    apply_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0);
      #1;
      exp_ra = (k > 4) ? 4 : k;
      check($sformatf("ovf_step%0d", k),
            32'({bus.rows_avail, bus.wr_full, bus.overflow_err}),
            32'({3'(exp_ra), (k >= 4) ? 1'b1 : 1'b0, (k == 5) ? 1'b1 : 1'b0}));
    end
    repeat (3) @(negedge clk);
    #1;
    check("ovf_sticky", 32'({bus.rows_avail, bus.wr_full, bus.overflow_err}),
          32'({3'd4, 1'b1, 1'b1}));
  endtask

  task automatic run_reset_mid();
    int   written = 0;
    bit   found = 0, found2 = 0;
    logic wd;
    apply_reset();
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1);
    for (int n = 0; n < 1000 && !found; n++) begin
      @(negedge clk);
      wd = (written < 16) && !bus.wr_full;
      if (wd) written++;
      drive(1'b0, wd, 1'b1);
      #1;
      if (bus.win_valid && bus.win_row == 4'd5 && bus.win_col == 4'd9) found = 1;
    end
    check("reach_row5_col9", 32'(found), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("async_reset", 32'(outs()), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check("reset_hold_mid", 32'(outs()), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("idle_after_reset", 32'({bus.rd_en, bus.win_valid, bus.rows_avail}), 32'd0);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b1);
    end
    for (int n = 0; n < 50 && !found2; n++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1);
      #1;
      if (bus.win_valid) found2 = 1;
    end
    check("restart_first_beat", 32'({found2, bus.win_row, bus.win_col}),
          32'({1'b1, 4'd0, 4'd0}));
  endtask

  initial begin
    bit got;
    tbl[0]  = mkv(0, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mkv(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 1, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 1, 1, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mkv(0, 1, 1, 0, 0, 0, 0, 2, 0);
    tbl[5]  = mkv(0, 0, 1, 0, 0, 0, 0, 3, 0);
    tbl[6]  = mkv(0, 0, 1, 1, 0, 0, 0, 3, 0);
    tbl[7]  = mkv(0, 0, 1, 1, 1, 1, 0, 3, 0);
    tbl[8]  = mkv(0, 0, 0, 0, 2, 1, 1, 3, 0);
    tbl[9]  = mkv(0, 0, 0, 0, 2, 1, 1, 3, 0);
    tbl[10] = mkv(0, 0, 1, 1, 2, 1, 1, 3, 0);
    tbl[11] = mkv(0, 0, 1, 1, 3, 1, 2, 3, 0);
    tbl[12] = mkv(0, 0, 1, 1, 4, 1, 3, 3, 0);
    tbl[13] = mkv(1, 0, 1, 1, 5, 1, 4, 3, 0);
    tbl[14] = mkv(0, 0, 1, 1, 6, 1, 5, 3, 0);

    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(1'($urandom), 1'($urandom), 1'($urandom));
      #1;
      check("reset_hold", 32'(outs()), 32'd0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    rst = 1'b1;

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(tbl[i].fs, tbl[i].wd, tbl[i].ordy);
      #1;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(mk_exp(tbl[i])));
    end

    // Finish sweep 0 and commit a row in the very cycle the oldest buffer is freed.
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b1);
      #1;
      if (bus.buf_free) begin
        got = 1;
        drive(1'b0, 1'b1, 1'b1);
      end
    end
    check("coinc_buf_free_seen", 32'(got), 32'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1);
    #1;
    check("coinc_rows_avail", 32'(bus.rows_avail), 32'd3);
    check("coinc_base", 32'(bus.rd_base_buf), 32'd1);

    run_full_frame();
    run_overflow();
    run_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
